// File: rtl/picorv32_mem_slave.sv
// picorv32 native-bus memory slave: word RAM with programmable wait states,
// a byte-output FIFO drained by valid/ready, and a sticky test-done register.
// Optional build macro MEM_SLAVE_CYCLE_CNT_EN adds a free-running cycle
// counter readable at IO_BASE+8; without it that address is unmapped.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for mem_valid
// WAIT   | burning WAIT_STATES cycles on the down-counter
// COMMIT | access performed here; stays put while OUT write finds FIFO full
// RESP   | mem_ready high for exactly this cycle, then back to IDLE
module picorv32_mem_slave #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] IO_BASE     = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        done,
  output logic [31:0] done_code,
  output logic        err
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [31:0] IO_OUT    = IO_BASE;
  localparam logic [31:0] IO_DONE   = IO_BASE + 32'd4;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;

  logic [31:0]   ram [MEM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic          is_write;
  logic          hit_ram;
  logic          hit_out;
  logic          hit_done;
  logic          hit_cnt;
  logic          unmapped;
  logic [AW-1:0] ram_idx;
  logic          fifo_full;
  logic          pop;
  logic          out_stall;
  logic          commit_fire;
  logic          push;
  logic [31:0]   rd_data;

`ifdef MEM_SLAVE_CYCLE_CNT_EN
  localparam logic [31:0] IO_CNT = IO_BASE + 32'd8;
  logic [31:0] cycle_cnt;

  // free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cycle_cnt <= 32'd0;
    else         cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign hit_cnt = (mem_addr[31:2] == IO_CNT[31:2]);
`else
  assign hit_cnt = 1'b0;
`endif

  // instruction fetches are plain reads; byte offset within a word is ignored
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_instr, mem_addr[1:0]};

  assign is_write  = |mem_wstrb;
  assign hit_ram   = (mem_addr < RAM_BYTES);
  assign hit_out   = (mem_addr[31:2] == IO_OUT[31:2]);
  assign hit_done  = (mem_addr[31:2] == IO_DONE[31:2]);
  assign unmapped  = !(hit_ram || hit_out || hit_done || hit_cnt);
  assign ram_idx   = mem_addr[AW+1:2];

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;

  // a simultaneous pop frees the slot on the same edge, so only stall without one
  assign out_stall   = hit_out && is_write && fifo_full && !out_ready;
  assign commit_fire = (state == S_COMMIT) && !out_stall;
  assign push        = commit_fire && hit_out && is_write;

  // read mux; RAM returns pre-write contents since the write lands on the same edge
  always_comb begin
    rd_data = 32'd0;
    if (hit_ram)       rd_data = ram[ram_idx];
    else if (hit_out)  rd_data = 32'(fifo_count);
    else if (hit_done) rd_data = done_code;
`ifdef MEM_SLAVE_CYCLE_CNT_EN
    else if (hit_cnt)  rd_data = cycle_cnt;
`endif
  end

  // bus handshake FSM with wait-state down-counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          mem_ready <= 1'b0;
          if (mem_valid) begin
            if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= S_COMMIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_COMMIT;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_COMMIT: begin
          if (commit_fire) begin
            state     <= S_RESP;
            mem_ready <= 1'b1;
            mem_rdata <= rd_data;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_ready <= 1'b0;
        end
      endcase
    end
  end

  // RAM write, byte lanes under mem_wstrb; contents survive reset
  always_ff @(posedge clk) begin
    if (commit_fire && hit_ram && is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) ram[ram_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // sticky done / err and the done code
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done      <= 1'b0;
      done_code <= 32'd0;
      err       <= 1'b0;
    end else if (commit_fire) begin
      if (hit_done && is_write) begin
        done      <= 1'b1;
        done_code <= mem_wdata;
      end
      if (unmapped) err <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-two depth
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; a push while full overwrites the slot being popped on the same edge
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

endmodule

// File: tb/tb_picorv32_mem_slave.sv
module tb_picorv32_mem_slave;

  localparam logic [31:0] IO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rstn0, rstn3;
  logic        valid0, valid3;
  logic        instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        out_ready;

  logic        ready0, ov0, done0, err0;
  logic [31:0] rdata0, dc0;
  logic [7:0]  od0;
  logic        ready3, ov3, done3, err3;
  logic [31:0] rdata3, dc3;
  logic [7:0]  od3;

  always #5 clk = ~clk;

  picorv32_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(0), .FIFO_DEPTH(8), .IO_BASE(IO)) dut0 (
    .clk(clk), .resetn(rstn0), .mem_valid(valid0), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(ready0), .mem_rdata(rdata0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .done(done0),
    .done_code(dc0), .err(err0));

  picorv32_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(3), .FIFO_DEPTH(8), .IO_BASE(IO)) dut3 (
    .clk(clk), .resetn(rstn3), .mem_valid(valid3), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(ready3), .mem_rdata(rdata3),
    .out_valid(ov3), .out_data(od3), .out_ready(out_ready), .done(done3),
    .done_code(dc3), .err(err3));

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_ram [16];
  logic [7:0]  m_fifo [$];
  logic        m_done, m_err;
  logic [31:0] m_code;

  logic [31:0] rd, f0, f1, f2, x1, x2, st_addr, a, wd, k_val, c0, c1, mask;
  logic [3:0]  ws;
  int          edges, idx, kind;
  logic        rose;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one bus transaction; returns read data and the number of edges to mem_ready
  task automatic access(input bit d3, input logic [31:0] ad, input logic [31:0] wdv,
                        input logic [3:0] wsv, input bit ins,
                        output logic [31:0] rdo, output int n);
    logic rdy;
    @(negedge clk);
    addr = ad; wdata = wdv; wstrb = wsv; instr = ins;
    if (d3) valid3 = 1'b1; else valid0 = 1'b1;
    n = 0;
    rdy = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      rdy = d3 ? ready3 : ready0;
    end while (!rdy && n < 64);
    rdo = d3 ? rdata3 : rdata0;
    valid0 = 1'b0; valid3 = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse_width", d3 ? ready3 : ready0, 1'b0);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn0 = 1'b0; rstn3 = 1'b0; valid0 = 1'b0; valid3 = 1'b0; instr = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ready", ready0, 1'b0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_out_valid", ov0, 1'b0);
    check("rst_out_data", od0, 8'h00);
    check("rst_done", done0, 1'b0);
    check("rst_done_code", dc0, 32'd0);
    check("rst_err", err0, 1'b0);
    check("rst_ready3", ready3, 1'b0);
    rstn0 = 1'b1; rstn3 = 1'b1;

    // program load, fetch, and the store the program performs
    access(0, 32'd0, 32'h01F00093, 4'hF, 0, rd, edges); check("lat_ws0", edges, 2);
    access(0, 32'd4, 32'h3FC00113, 4'hF, 0, rd, edges); check("lat_ws0", edges, 2);
    access(0, 32'd8, 32'h0020A023, 4'hF, 0, rd, edges); check("lat_ws0", edges, 2);
    access(0, 32'd0, 32'd0, 4'h0, 1, f0, edges); check("fetch0", f0, 32'h01F00093);
    access(0, 32'd4, 32'd0, 4'h0, 1, f1, edges); check("fetch1", f1, 32'h3FC00113);
    access(0, 32'd8, 32'd0, 4'h0, 1, f2, edges); check("fetch2", f2, 32'h0020A023);
    x1 = 32'($signed(f0[31:20]));
    x2 = 32'($signed(f1[31:20]));
    st_addr = x1 + 32'($signed({f2[31:25], f2[11:7]}));
    access(0, st_addr, x2, 4'hF, 0, rd, edges);
    access(0, 32'd28, 32'd0, 4'h0, 0, rd, edges); check("prog_store", rd, 32'h000003FC);

    // byte lanes and the last RAM word
    access(0, 32'd20, 32'hAABBCCDD, 4'hF, 0, rd, edges);
    access(0, 32'd20, 32'h11223344, 4'b0101, 0, rd, edges);
    access(0, 32'd20, 32'd0, 4'h0, 0, rd, edges); check("byte_lane", rd, 32'hAA22CC44);
    access(0, 32'd1020, 32'h5A5AA5A5, 4'hF, 0, rd, edges);
    access(0, 32'd1020, 32'd0, 4'h0, 0, rd, edges); check("last_word", rd, 32'h5A5AA5A5);
    check("err_after_ram", err0, 1'b0);

    // FIFO fill, stall on the ninth write, release with a single pop
    for (int i = 0; i < 8; i++) begin
      access(0, IO, 32'h41 + i, 4'h1, 0, rd, edges);
      check("fifo_fill_lat", edges, 2);
    end
    access(0, IO, 32'd0, 4'h0, 0, rd, edges); check("fifo_count_full", rd, 32'd8);
    @(negedge clk);
    addr = IO; wdata = 32'h49; wstrb = 4'h1; valid0 = 1'b1;
    rose = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready0) rose = 1'b1;
    end
    check("fifo_stall", rose, 1'b0);
    @(negedge clk);
    check("fifo_head_first", od0, 8'h41);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("fifo_release", ready0, 1'b1);
    valid0 = 1'b0;
    @(posedge clk); #1;
    check("fifo_release_width", ready0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain_valid", ov0, 1'b1);
      check("drain_data", od0, 8'h42 + i);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("drain_empty", ov0, 1'b0);

    // DONE register and unmapped access
    access(0, IO + 32'd4, 32'h0000CAFE, 4'hF, 0, rd, edges);
    check("done_set", done0, 1'b1);
    check("done_code", dc0, 32'h0000CAFE);
    access(0, IO + 32'd4, 32'd0, 4'h0, 0, rd, edges); check("done_read", rd, 32'h0000CAFE);
    check("err_before_unmapped", err0, 1'b0);
    access(0, 32'h2000_0000, 32'd0, 4'h0, 0, rd, edges);
    check("unmapped_rdata", rd, 32'd0);
    check("unmapped_lat", edges, 2);
    check("unmapped_err", err0, 1'b1);

    // randomized traffic against the reference model
    m_done = 1'b1; m_code = 32'h0000CAFE; m_err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_ram[i] = $urandom;
      access(0, 32'(4 * i), m_ram[i], 4'hF, 0, rd, edges);
    end
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          idx = $urandom_range(0, 15); wd = $urandom; ws = 4'($urandom_range(1, 15));
          mask = lane_mask(ws);
          m_ram[idx] = (m_ram[idx] & ~mask) | (wd & mask);
          access(0, 32'(4 * idx) | 32'($urandom_range(0, 3)), wd, ws, 0, rd, edges);
        end
        1: begin
          idx = $urandom_range(0, 15);
          access(0, 32'(4 * idx), 32'd0, 4'h0, $urandom_range(0, 1) == 1, rd, edges);
          check("rand_ram_read", rd, m_ram[idx]);
        end
        2: begin
          if (m_fifo.size() < 8 && $urandom_range(0, 1) == 1) begin
            wd = $urandom;
            m_fifo.push_back(wd[7:0]);
            access(0, IO, wd, 4'($urandom_range(1, 15)), 0, rd, edges);
          end else begin
            access(0, IO, 32'd0, 4'h0, 0, rd, edges);
            check("rand_out_count", rd, 32'(m_fifo.size()));
          end
        end
        3: begin
          if ($urandom_range(0, 1) == 1) begin
            wd = $urandom; m_code = wd; m_done = 1'b1;
            access(0, IO + 32'd4, wd, 4'hF, 0, rd, edges);
          end else begin
            access(0, IO + 32'd4, 32'd0, 4'h0, 0, rd, edges);
            check("rand_done_read", rd, m_code);
          end
        end
        default: begin
          case ($urandom_range(0, 2))
            0:       a = IO + 32'd12;
            1:       a = 32'h2000_0000 | ($urandom & 32'h00FF_FFFC);
            default: a = 32'd1024;
          endcase
          m_err = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            access(0, a, $urandom, 4'hF, 0, rd, edges);
          end else begin
            access(0, a, 32'd0, 4'h0, 0, rd, edges);
            check("rand_unmapped_read", rd, 32'd0);
          end
        end
      endcase
      check("rand_latency", edges, 2);
      check("rand_done", done0, m_done);
      check("rand_done_code", dc0, m_code);
      check("rand_err", err0, m_err);
      check("rand_out_valid", ov0, m_fifo.size() != 0);
      if (m_fifo.size() != 0) check("rand_out_head", od0, m_fifo[0]);
    end
    while (m_fifo.size() != 0) begin
      @(negedge clk);
      check("rand_drain", od0, m_fifo.pop_front());
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("rand_drain_empty", ov0, 1'b0);

    // wait-state latency on the WAIT_STATES=3 instance
    access(1, 32'd4, 32'hDEADBEEF, 4'hF, 0, rd, edges); check("lat_ws3_write", edges, 5);
    access(1, 32'd4, 32'd0, 4'h0, 0, rd, edges);
    check("lat_ws3_read", edges, 5);
    check("ws3_rdata", rd, 32'hDEADBEEF);
    k_val = 32'h0BADF00D;
    access(1, 32'd8, k_val, 4'hF, 0, rd, edges);

    // reset in the middle of WAIT abandons the write
    @(negedge clk);
    addr = 32'd8; wdata = ~k_val; wstrb = 4'hF; valid3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn3 = 1'b0;
    #1;
    check("rst_mid_ready", ready3, 1'b0);
    rose = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready3) rose = 1'b1;
    end
    check("rst_mid_no_ready", rose, 1'b0);
    valid3 = 1'b0;
    @(negedge clk);
    rstn3 = 1'b1;
    access(1, 32'd8, 32'd0, 4'h0, 0, rd, edges);
    check("rst_mid_ram", rd, k_val);
    check("rst_mid_follow_lat", edges, 5);
    check("ws3_err_clean", err3, 1'b0);

`ifdef MEM_SLAVE_CYCLE_CNT_EN
    access(1, IO + 32'd8, 32'd0, 4'h0, 0, c0, edges);
    access(1, IO + 32'd8, 32'd0, 4'h0, 0, c1, edges);
    check("cycle_cnt_advances", c1 > c0, 1'b1);
    check("cycle_cnt_no_err", err3, 1'b0);
`else
    access(1, IO + 32'd8, 32'd0, 4'h0, 0, rd, edges);
    check("io8_unmapped_rdata", rd, 32'd0);
    check("io8_unmapped_err", err3, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
